demapper: RTL and testbench
===========================

DEMAPPER -- requirements
Module: demapper

Interface
REQ-001 The block SHALL have parameter PHASES, default 16, meaning parallel samples per beat.
REQ-002 The block SHALL have parameter WIDTH, default 3, meaning bit field per lane and component.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable_i, input, 1 bit: when 0, all pipeline registers hold.
REQ-006 The block SHALL have port valid_i, input, 1 bit: input beat valid.
REQ-007 The block SHALL have port modScheme_i, input, 2 bits: 00 QPSK, 10 16-QAM, 11 64-QAM, 01 reserved.
REQ-008 The block SHALL have ports data_i_i and data_q_i, input, PHASES*16 bits each: per-lane signed Q5.11 samples, lane k at [16k+15:16k].
REQ-009 The block SHALL have port clr_cnt_i, input, 1 bit: clears the overrange counter.
REQ-010 The block SHALL have port valid_o, output, 1 bit: output beat valid.
REQ-011 The block SHALL have ports data_i_o and data_q_o, output, PHASES*WIDTH bits each: hard-decision bits.
REQ-012 The block SHALL have port mod_err_o, output, 1 bit: the current output beat carried reserved mode 01.
REQ-013 The block SHALL have port ovr_cnt_o, output, 16 bits: saturating count of overrange beats.

Function
REQ-014 Stage 1 SHALL register the data, modScheme_i and valid_i on a clock with enable_i=1; stage 2 SHALL register the sliced bits and valid_o. The latency SHALL be exactly 2 enabled clocks.
REQ-015 Mode SHALL travel with its beat, so a per-beat mode change SHALL take effect on that beat with no bubble.
REQ-016 In QPSK, lane k SHALL put bit (sample >= 0) at bit k; all higher bits SHALL be 0.
REQ-017 In 16-QAM, with T=0x512, lane k SHALL place its 2-bit field at [2k+1:2k]: <-T gives 00, [-T,0) gives 01, [0,T) gives 11, >=T gives 10. Higher bits SHALL be 0.
REQ-018 In 64-QAM, with thresholds 0x278/0x4F0/0x768 (±), lane k SHALL place its 3-bit field at [3k+2:3k] as the natural-binary region index, 000 (<-0x768) through 111 (>=0x768).
REQ-019 A sample exactly on a threshold SHALL fall in the upper region; a sample of 0 SHALL be treated as positive.
REQ-020 Reserved mode 01 SHALL output all-zero bits with valid_o asserted and mod_err_o=1.
REQ-021 A lane/component SHALL be overrange if |sample| exceeds 0xB52 (QPSK), 0xA24 (16-QAM) or 0x9E0 (64-QAM).
REQ-022 ovr_cnt_o SHALL increment by 1 per valid output beat with any lane overrange, and SHALL saturate at 0xFFFF.
REQ-023 If clr_cnt_i and an increment occur in the same clock, clr_cnt_i SHALL win and the counter SHALL become 0.
REQ-024 When valid_i=0 the data registers MAY update, but valid_o SHALL deassert after the 2-clock latency and the counter SHALL NOT change.

Reset
REQ-025 With rst_i=1 at a clock edge, valid_o, mod_err_o, data_i_o, data_q_o, ovr_cnt_o and all stage registers SHALL become 0, regardless of enable_i.
REQ-026 Beats in flight when reset asserts mid-stream SHALL be discarded, and no valid_o SHALL appear for them.

Structure
REQ-027 Package demapper_pkg SHALL hold the mode codes, the scaling constants 0x5A9/0x289/0x13C, the slicing thresholds and the overrange limits.
REQ-028 A combinational sub-module demap_slicer (one 16-bit sample plus mode in, WIDTH bits and an overrange flag out) SHALL be instantiated 2*PHASES times.

Verification
REQ-029 The bench SHALL cover: QPSK, lane0 I=+0x5A9, Q=-0x5A9 -> data_i_o[0]=1, data_q_o[0]=0, upper bits 0, valid_o 2 clocks after valid_i.
REQ-030 The bench SHALL cover: 16-QAM, I values -0x79B, -0x289, +0x289, +0x79B across lanes 0-3 -> fields 00, 01, 11, 10.
REQ-031 The bench SHALL cover: 64-QAM, I=+0x768 -> 111 and I=+0x767 -> 110; I=0 -> 100.
REQ-032 The bench SHALL cover: back-to-back beats alternating QPSK and 64-QAM -> each output decoded in its own mode, with valid_o continuous.
REQ-033 The bench SHALL cover: 3 beats with lane5 Q=+0xC00 in QPSK, then clr_cnt_i coincident with a 4th overrange beat -> ovr_cnt_o reaches 3, then 0.
REQ-034 The bench SHALL cover: mode 01 -> mod_err_o=1 with zero bits; rst_i pulsed one clock after valid_i -> no valid_o and counter 0.

Source files
------------

// File: rtl/demapper_pkg.sv
// ============================================================================
//  Module      : demapper_pkg
//  Description : Mode codes, scaling, slicing thresholds and overrange limits
//                shared by the demapper and its per-sample slicer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demapper_pkg;

    typedef enum logic [1:0] {
        MODE_QPSK  = 2'b00,
        MODE_RSVD  = 2'b01,
        MODE_QAM16 = 2'b10,
        MODE_QAM64 = 2'b11
    } mode_e;

    // Nominal constellation point amplitudes (Q5.11) for each modulation.
    localparam logic signed [15:0] c_scale_qpsk  = 16'sh05A9;
    localparam logic signed [15:0] c_scale_qam16 = 16'sh0289;
    localparam logic signed [15:0] c_scale_qam64 = 16'sh013C;

    localparam logic signed [15:0] c_thr16   = 16'sh0512;
    localparam logic signed [15:0] c_thr16_n = -c_thr16;

    localparam logic signed [15:0] c_thr64_1   = 16'sh0278;
    localparam logic signed [15:0] c_thr64_2   = 16'sh04F0;
    localparam logic signed [15:0] c_thr64_3   = 16'sh0768;
    localparam logic signed [15:0] c_thr64_1_n = -c_thr64_1;
    localparam logic signed [15:0] c_thr64_2_n = -c_thr64_2;
    localparam logic signed [15:0] c_thr64_3_n = -c_thr64_3;

    localparam logic [16:0] c_lim_qpsk  = 17'h00B52;
    localparam logic [16:0] c_lim_qam16 = 17'h00A24;
    localparam logic [16:0] c_lim_qam64 = 17'h009E0;

endpackage

`default_nettype wire

// File: rtl/demap_slicer.sv
// ============================================================================
//  Module      : demap_slicer
//  Description : Hard-decision slicer for one signed Q5.11 component.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demap_slicer
    import demapper_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic signed [15:0] i_sample,
    input  mode_e              i_mode,
    output logic [WIDTH-1:0]   o_bits,
    output logic               o_ovr
);

    logic [2:0]  w_field;
    logic [16:0] w_ext;
    logic [16:0] w_mag;
    logic [16:0] w_lim;
    logic        w_chk;

    // 17-bit magnitude so that -32768 does not wrap.
    assign w_ext = {i_sample[15], i_sample};
    assign w_mag = w_ext[16] ? (17'd0 - w_ext) : w_ext;

    always_comb begin
        w_field = 3'b000;
        w_lim   = 17'h1FFFF;
        w_chk   = 1'b0;
        case (i_mode)
            MODE_QPSK: begin
                w_field = {2'b00, ~i_sample[15]};
                w_lim   = c_lim_qpsk;
                w_chk   = 1'b1;
            end
            MODE_QAM16: begin
                if (i_sample < c_thr16_n)
                    w_field = 3'b000;
                else if (i_sample[15])
                    w_field = 3'b001;
                else if (i_sample < c_thr16)
                    w_field = 3'b011;
                else
                    w_field = 3'b010;
                w_lim = c_lim_qam16;
                w_chk = 1'b1;
            end
            MODE_QAM64: begin
                if (i_sample[15])
                    w_field = (i_sample < c_thr64_2_n) ?
                              ((i_sample < c_thr64_3_n) ? 3'd0 : 3'd1) :
                              ((i_sample < c_thr64_1_n) ? 3'd2 : 3'd3);
                else
                    w_field = (i_sample < c_thr64_2) ?
                              ((i_sample < c_thr64_1) ? 3'd4 : 3'd5) :
                              ((i_sample < c_thr64_3) ? 3'd6 : 3'd7);
                w_lim = c_lim_qam64;
                w_chk = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_bits = WIDTH'(w_field);
    assign o_ovr  = w_chk && (w_mag > w_lim);

endmodule

`default_nettype wire

// File: rtl/demapper.sv
// ============================================================================
//  Module      : demapper
//  Description : Two-stage multi-lane QPSK/16-QAM/64-QAM hard demapper with
//                saturating overrange beat counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demapper
    import demapper_pkg::*;
#(
    parameter int PHASES = 16,
    parameter int WIDTH  = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      valid_i,
    input  logic [1:0]                modScheme_i,
    input  logic [PHASES*16-1:0]      data_i_i,
    input  logic [PHASES*16-1:0]      data_q_i,
    input  logic                      clr_cnt_i,
    output logic                      valid_o,
    output logic [PHASES*WIDTH-1:0]   data_i_o,
    output logic [PHASES*WIDTH-1:0]   data_q_o,
    output logic                      mod_err_o,
    output logic [15:0]               ovr_cnt_o
);

    logic [PHASES*16-1:0]    r_data_i;
    logic [PHASES*16-1:0]    r_data_q;
    mode_e                   r_mode;
    logic                    r_valid;

    logic [WIDTH-1:0]        w_fld_i [PHASES];
    logic [WIDTH-1:0]        w_fld_q [PHASES];
    logic [PHASES-1:0]       w_ovr_i;
    logic [PHASES-1:0]       w_ovr_q;
    logic [PHASES*WIDTH-1:0] w_pack_i;
    logic [PHASES*WIDTH-1:0] w_pack_q;
    logic                    w_any_ovr;

    // The mode is staged alongside its beat so mode switches need no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_i <= '0;
            r_data_q <= '0;
            r_mode   <= MODE_QPSK;
            r_valid  <= 1'b0;
        end else if (enable_i) begin
            r_data_i <= data_i_i;
            r_data_q <= data_q_i;
            r_mode   <= mode_e'(modScheme_i);
            r_valid  <= valid_i;
        end
    end

    generate
        for (genvar k = 0; k < PHASES; k++) begin : g_lane
            demap_slicer #(.WIDTH(WIDTH)) u_slice_i (
                .i_sample (r_data_i[16*k +: 16]),
                .i_mode   (r_mode),
                .o_bits   (w_fld_i[k]),
                .o_ovr    (w_ovr_i[k])
            );
            demap_slicer #(.WIDTH(WIDTH)) u_slice_q (
                .i_sample (r_data_q[16*k +: 16]),
                .i_mode   (r_mode),
                .o_bits   (w_fld_q[k]),
                .o_ovr    (w_ovr_q[k])
            );
        end
    endgenerate

    // Field stride per lane follows bits-per-symbol; unused upper bits stay 0.
    always_comb begin
        w_pack_i = '0;
        w_pack_q = '0;
        for (int k = 0; k < PHASES; k++) begin
            case (r_mode)
                MODE_QPSK: begin
                    w_pack_i[k] = w_fld_i[k][0];
                    w_pack_q[k] = w_fld_q[k][0];
                end
                MODE_QAM16: begin
                    w_pack_i[2*k +: 2] = w_fld_i[k][1:0];
                    w_pack_q[2*k +: 2] = w_fld_q[k][1:0];
                end
                MODE_QAM64: begin
                    w_pack_i[3*k +: 3] = w_fld_i[k][2:0];
                    w_pack_q[3*k +: 3] = w_fld_q[k][2:0];
                end
                default: ;
            endcase
        end
    end

    assign w_any_ovr = |{w_ovr_i, w_ovr_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            data_i_o  <= '0;
            data_q_o  <= '0;
            mod_err_o <= 1'b0;
            ovr_cnt_o <= 16'h0000;
        end else begin
            if (enable_i) begin
                valid_o   <= r_valid;
                data_i_o  <= w_pack_i;
                data_q_o  <= w_pack_q;
                mod_err_o <= r_valid && (r_mode == MODE_RSVD);
            end
            if (clr_cnt_i)
                ovr_cnt_o <= 16'h0000;
            else if (enable_i && r_valid && w_any_ovr && (ovr_cnt_o != 16'hFFFF))
                ovr_cnt_o <= ovr_cnt_o + 16'h0001;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_demapper.sv
// ============================================================================
//  Module      : tb_demapper
//  Description : Scoreboard bench for demapper with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demapper;
    import demapper_pkg::*;

    localparam int P  = 16;
    localparam int W  = 3;
    localparam int DW = P*16;
    localparam int OW = P*W;

    logic          clk = 1'b0;
    logic          rst_i, enable_i, valid_i, clr_cnt_i;
    logic [1:0]    modScheme_i;
    logic [DW-1:0] data_i_i, data_q_i;
    logic          valid_o, mod_err_o;
    logic [OW-1:0] data_i_o, data_q_o;
    logic [15:0]   ovr_cnt_o;

    always #5 clk = ~clk;

    demapper #(.PHASES(P), .WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .valid_i     (valid_i),
        .modScheme_i (modScheme_i),
        .data_i_i    (data_i_i),
        .data_q_i    (data_q_i),
        .clr_cnt_i   (clr_cnt_i),
        .valid_o     (valid_o),
        .data_i_o    (data_i_o),
        .data_q_o    (data_q_o),
        .mod_err_o   (mod_err_o),
        .ovr_cnt_o   (ovr_cnt_o)
    );

    typedef struct {
        logic [OW-1:0] di;
        logic [OW-1:0] dq;
        logic          err;
        int            cyc;
        string         name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 expected no beat");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_data_i"}, data_i_o, e.di);
                chk({e.name, "_data_q"}, data_q_o, e.dq);
                chk({e.name, "_mod_err"}, OW'(mod_err_o), OW'(e.err));
                chk({e.name, "_latency"}, OW'(cyc), OW'(e.cyc));
            end
        end
    end

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < P; k++) r[16*k +: 16] = v;
        return r;
    endfunction

    task automatic send(input string name, input logic [1:0] mode,
                        input logic [DW-1:0] vi, input logic [DW-1:0] vq,
                        input logic [OW-1:0] ei, input logic [OW-1:0] eq, input logic err);
        valid_i     = 1'b1;
        modScheme_i = mode;
        data_i_i    = vi;
        data_q_i    = vq;
        sb.push_back('{di: ei, dq: eq, err: err, cyc: cyc + 2, name: name});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid_i  = 1'b0;
        data_i_i = '0;
        data_q_i = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] vi, vq, ovr_q;

        rst_i = 1'b1; enable_i = 1'b1; valid_i = 1'b0; clr_cnt_i = 1'b0;
        modScheme_i = 2'b00; data_i_i = '0; data_q_i = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_valid",   OW'(valid_o),   '0);
        chk("reset_mod_err", OW'(mod_err_o), '0);
        chk("reset_data_i",  data_i_o,       '0);
        chk("reset_cnt",     OW'(ovr_cnt_o), '0);
        rst_i = 1'b0;
        idle(2);

        // QPSK: zero lanes count as positive
        vi = rep(16'h0000); vi[15:0] = c_scale_qpsk;
        vq = rep(16'h0000); vq[15:0] = -c_scale_qpsk;
        send("qpsk", 2'b00, vi, vq, 48'h0000_0000_FFFF, 48'h0000_0000_FFFE, 1'b0);
        idle(3);

        vi = rep(16'h0000);
        vi[15:0]  = -16'sh079B;
        vi[31:16] = -c_scale_qam16;
        vi[47:32] = c_scale_qam16;
        vi[63:48] = 16'sh079B;
        send("qam16", 2'b10, vi, rep(16'h0000), 48'h0000_FFFF_FFB4, 48'h0000_FFFF_FFFF, 1'b0);
        idle(3);

        // 64-QAM boundaries: +0x768, +0x767, 0, -0x768, -0x769
        vi = rep(16'h0000);
        vi[15:0]  = 16'h0768;
        vi[31:16] = 16'h0767;
        vi[47:32] = 16'h0000;
        vi[63:48] = -16'sh0768;
        vi[79:64] = -16'sh0769;
        send("qam64", 2'b11, vi, rep(16'h0000), 48'h9249_2492_0337, 48'h9249_2492_4924, 1'b0);
        idle(3);

        for (int b = 0; b < 4; b++) begin
            if (b % 2 == 0)
                send("b2b_qpsk", 2'b00, rep(-16'sh0100), rep(16'h0100),
                     48'h0, 48'h0000_0000_FFFF, 1'b0);
            else
                send("b2b_qam64", 2'b11, rep(16'h0300), rep(-16'sh0300),
                     48'hB6DB_6DB6_DB6D, 48'h4924_9249_2492, 1'b0);
        end
        idle(3);

        send("reserved", 2'b01, rep(16'h0100), rep(-16'sh0100), 48'h0, 48'h0, 1'b1);
        idle(3);
        chk("cnt_after_clean", OW'(ovr_cnt_o), 48'd0);

        ovr_q = rep(16'h0000); ovr_q[95:80] = 16'h0C00;
        for (int b = 0; b < 3; b++)
            send("ovr", 2'b00, rep(16'h0000), ovr_q, 48'hFFFF, 48'hFFFF, 1'b0);
        idle(3);
        chk("cnt_three", OW'(ovr_cnt_o), 48'd3);

        // Clear lands on the same edge as the 4th beat's increment
        send("ovr4", 2'b00, rep(16'h0000), ovr_q, 48'hFFFF, 48'hFFFF, 1'b0);
        valid_i = 1'b0; clr_cnt_i = 1'b1;
        @(posedge clk); #1;
        clr_cnt_i = 1'b0;
        chk("cnt_clr_wins", OW'(ovr_cnt_o), 48'd0);
        idle(2);
        chk("cnt_clr_stays", OW'(ovr_cnt_o), 48'd0);

        send("ovr5", 2'b00, rep(16'h0000), ovr_q, 48'hFFFF, 48'hFFFF, 1'b0);
        idle(3);
        chk("cnt_one", OW'(ovr_cnt_o), 48'd1);

        // Overrange data without valid must not count
        valid_i = 1'b0; modScheme_i = 2'b00; data_q_i = ovr_q;
        repeat (3) begin @(posedge clk); #1; end
        chk("cnt_invalid_hold", OW'(ovr_cnt_o), 48'd1);

        // Reset one clock after an overrange beat: beat dropped, counter zeroed
        valid_i = 1'b1; modScheme_i = 2'b00; data_i_i = '0; data_q_i = ovr_q;
        @(posedge clk); #1;
        valid_i = 1'b0; rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        idle(4);
        chk("rst_cnt", OW'(ovr_cnt_o), 48'd0);
        chk("rst_valid", OW'(valid_o), 48'd0);

        idle(2);
        chk("scoreboard_drain", OW'(sb.size()), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
